ps2_key_mailbox: RTL

PS2_KEY_MAILBOX -- requirements
Module: ps2_key_mailbox

---
 rtl/ps2_key_mailbox_pkg.sv | 68 ++++++
 rtl/ps2_key_fifo.sv | 69 ++++++
 rtl/ps2_key_mailbox.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_mailbox_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_key_mailbox_pkg
//  Brief   : Shared constants, scan-code map and FSM encodings for the PS/2
//            key mailbox.
//  Rev     : 1.0  initial release
// ============================================================================
package ps2_key_mailbox_pkg;

    localparam logic [2:0] c_code_none    = 3'd0;
    localparam logic [2:0] c_code_up      = 3'd1;
    localparam logic [2:0] c_code_down    = 3'd2;
    localparam logic [2:0] c_code_left    = 3'd3;
    localparam logic [2:0] c_code_right   = 3'd4;
    localparam logic [2:0] c_code_restart = 3'd5;

    localparam logic [7:0] c_sc_ext       = 8'hE0;
    localparam logic [7:0] c_sc_brk       = 8'hF0;
    localparam logic [7:0] c_sc_up_ext    = 8'h75;
    localparam logic [7:0] c_sc_down_ext  = 8'h72;
    localparam logic [7:0] c_sc_left_ext  = 8'h6B;
    localparam logic [7:0] c_sc_right_ext = 8'h74;
    localparam logic [7:0] c_sc_up        = 8'h1D;
    localparam logic [7:0] c_sc_down      = 8'h1B;
    localparam logic [7:0] c_sc_left      = 8'h1C;
    localparam logic [7:0] c_sc_right     = 8'h23;
    localparam logic [7:0] c_sc_restart   = 8'h76;

    typedef enum logic [1:0] {
        D_IDLE    = 2'd0,
        D_EXT     = 2'd1,
        D_BRK     = 2'd2,
        D_EXT_BRK = 2'd3
    } dec_state_t;

    typedef enum logic [1:0] {
        W_IDLE     = 2'd0,
        W_WRITE    = 2'd1,
        W_WAIT_ACK = 2'd2
    } wr_state_t;

    // Extended and plain scan codes live in separate tables: 0x75 alone is not "up".
    function automatic logic [2:0] map_make(input logic ext, input logic [7:0] sc);
        logic [2:0] code;
        code = c_code_none;
        if (ext) begin
            case (sc)
                c_sc_up_ext:    code = c_code_up;
                c_sc_down_ext:  code = c_code_down;
                c_sc_left_ext:  code = c_code_left;
                c_sc_right_ext: code = c_code_right;
                default:        code = c_code_none;
            endcase
        end else begin
            case (sc)
                c_sc_up:        code = c_code_up;
                c_sc_down:      code = c_code_down;
                c_sc_left:      code = c_code_left;
                c_sc_right:     code = c_code_right;
                c_sc_restart:   code = c_code_restart;
                default:        code = c_code_none;
            endcase
        end
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_key_fifo
//  Brief   : Small synchronous FIFO for decoded key codes; simultaneous push
//            and pop are honoured even when full.
//  Rev     : 1.0  initial release
// ============================================================================
module ps2_key_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_aw-1:0] c_last  = c_aw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);
    assign dout  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same edge, so a push into a full FIFO may proceed.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_mailbox.sv
`default_nettype none
// ============================================================================
//  Module  : ps2_key_mailbox
//  Brief   : Decodes PS/2 scan codes into direction/restart codes, buffers
//            them and posts each one to a RAM mailbox word until acknowledged.
//  Rev     : 1.0  initial release
// ============================================================================
module ps2_key_mailbox
    import ps2_key_mailbox_pkg::*;
#(
    parameter logic [9:0] MAILBOX_ADDR = 10'd1007,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_ready,
    input  logic [7:0]  ps2_byte,
    input  logic [9:0]  disp_addr,
    input  logic        key_ack,
    output logic [9:0]  ram_addrb,
    output logic        ram_web,
    output logic [31:0] ram_dinb,
    output logic        key_pending,
    output logic        overflow
);

    dec_state_t r_dec_state;
    dec_state_t w_dec_next;
    wr_state_t  r_wr_state;
    wr_state_t  w_wr_next;

    logic       w_evt_make;
    logic       w_evt_break;
    logic       w_evt_ext;
    logic [2:0] w_make_code;
    logic       w_hold_match;
    logic       w_push;
    logic       w_pop;
    logic [2:0] w_fifo_dout;
    logic       w_fifo_full;
    logic       w_fifo_empty;

    logic       r_hold_valid;
    logic       r_hold_ext;
    logic [7:0] r_hold_sc;
    logic       r_overflow;
    logic [31:0] r_dinb;

    // ---------------- decoder ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec_state <= D_IDLE;
        end else begin
            r_dec_state <= w_dec_next;
        end
    end

    always_comb begin
        w_dec_next = r_dec_state;
        if (ps2_ready) begin
            case (r_dec_state)
                D_IDLE: begin
                    if (ps2_byte == c_sc_ext) begin
                        w_dec_next = D_EXT;
                    end else if (ps2_byte == c_sc_brk) begin
                        w_dec_next = D_BRK;
                    end else begin
                        w_dec_next = D_IDLE;
                    end
                end
                D_EXT:     w_dec_next = (ps2_byte == c_sc_brk) ? D_EXT_BRK : D_IDLE;
                D_BRK:     w_dec_next = D_IDLE;
                D_EXT_BRK: w_dec_next = D_IDLE;
                default:   w_dec_next = D_IDLE;
            endcase
        end
    end

    always_comb begin
        w_evt_make  = 1'b0;
        w_evt_break = 1'b0;
        w_evt_ext   = 1'b0;
        if (ps2_ready) begin
            case (r_dec_state)
                D_IDLE: begin
                    w_evt_make = (ps2_byte != c_sc_ext) && (ps2_byte != c_sc_brk);
                end
                D_EXT: begin
                    w_evt_make = (ps2_byte != c_sc_brk);
                    w_evt_ext  = 1'b1;
                end
                D_BRK: begin
                    w_evt_break = 1'b1;
                end
                D_EXT_BRK: begin
                    w_evt_break = 1'b1;
                    w_evt_ext   = 1'b1;
                end
                default: begin
                    w_evt_make = 1'b0;
                end
            endcase
        end
    end

    assign w_make_code  = map_make(w_evt_ext, ps2_byte);
    assign w_hold_match = r_hold_valid && (r_hold_ext == w_evt_ext) && (r_hold_sc == ps2_byte);
    assign w_push       = w_evt_make && (w_make_code != c_code_none) && !w_hold_match;

    // Typematic hold: remembers the last accepted make until that same key breaks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_ext   <= 1'b0;
            r_hold_sc    <= 8'h00;
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_hold_ext   <= w_evt_ext;
            r_hold_sc    <= ps2_byte;
        end else if (w_evt_break && w_hold_match) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    ps2_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_make_code),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ---------------- mailbox writer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:     w_wr_next = w_fifo_empty ? W_IDLE : W_WRITE;
            W_WRITE:    w_wr_next = W_WAIT_ACK;
            W_WAIT_ACK: w_wr_next = key_ack ? W_IDLE : W_WAIT_ACK;
            default:    w_wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = (r_wr_state == W_IDLE) && !w_fifo_empty;
        ram_web     = (r_wr_state == W_WRITE);
        ram_addrb   = (r_wr_state == W_WRITE) ? MAILBOX_ADDR : disp_addr;
        key_pending = (r_wr_state == W_WRITE) || (r_wr_state == W_WAIT_ACK);
    end

    // Write data is captured at the pop so it is stable throughout W_WRITE and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dinb <= 32'd0;
        end else if (w_pop) begin
            r_dinb <= {29'd0, w_fifo_dout};
        end
    end

    assign ram_dinb = r_dinb;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
